// File: rtl/baud_pkg.sv
// Shared constants for the programmable fractional baud-rate generator.
package baud_pkg;

  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OVS      = 16;
  localparam int MIN_DIV  = 2;
  localparam int DEF_INT  = 54;
  localparam int DEF_FRAC = 4;
  localparam int PH_W     = $clog2(OVS);

endpackage

// File: rtl/baud_frac_div.sv
// Fractional clock divider: produces one oversample strobe every int+c clocks,
// where c is the carry out of a FRAC_W-bit phase accumulator.
module baud_frac_div #(
  parameter int DIV_W  = baud_pkg::DIV_W,
  parameter int FRAC_W = baud_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic [DIV_W-1:0]  int_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              term_o,
  output logic              tick_os_o
);

  logic [DIV_W-1:0]  os_cnt_q, os_cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              c_q, c_d;
  logic              tick_os_q, tick_os_d;
  logic [DIV_W:0]    last_s;
  logic              term_s;

  // Last count of the current interval; one bit wider so int+c-1 cannot overflow.
  assign last_s = {1'b0, int_i} - {{DIV_W{1'b0}}, 1'b1} + {{DIV_W{1'b0}}, c_q};
  assign term_s = en_i && ({1'b0, os_cnt_q} == last_s);

  assign term_o    = term_s;
  assign tick_os_o = tick_os_q;

  // Next-state: clear beats terminal, terminal beats plain counting.
  always_comb begin
    os_cnt_d  = os_cnt_q;
    acc_d     = acc_q;
    c_d       = c_q;
    tick_os_d = 1'b0;
    if (clear_i) begin
      os_cnt_d = {DIV_W{1'b0}};
      acc_d    = {FRAC_W{1'b0}};
      c_d      = 1'b0;
    end else if (term_s) begin
      os_cnt_d     = {DIV_W{1'b0}};
      {c_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
      tick_os_d    = 1'b1;
    end else if (en_i) begin
      os_cnt_d = os_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      os_cnt_d = os_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt_q  <= {DIV_W{1'b0}};
      acc_q     <= {FRAC_W{1'b0}};
      c_q       <= 1'b0;
      tick_os_q <= 1'b0;
    end else begin
      os_cnt_q  <= os_cnt_d;
      acc_q     <= acc_d;
      c_q       <= c_d;
      tick_os_q <= tick_os_d;
    end
  end

endmodule

// File: rtl/baud_gen_prog.sv
// Programmable baud generator: divisor shadow registers, oversample phase
// counter, and registered baud / mid-bit / load-error strobes.
module baud_gen_prog #(
  parameter int DIV_W    = baud_pkg::DIV_W,
  parameter int FRAC_W   = baud_pkg::FRAC_W,
  parameter int OVS      = baud_pkg::OVS,
  parameter int DEF_INT  = baud_pkg::DEF_INT,
  parameter int DEF_FRAC = baud_pkg::DEF_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              restart,
  output logic              tick_os,
  output logic              tick_baud,
  output logic              tick_mid,
  output logic              div_err
);

  localparam int PH_W = $clog2(OVS);

  logic [DIV_W-1:0]  int_q, int_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic              tick_baud_q, tick_baud_d;
  logic              tick_mid_q, tick_mid_d;
  logic              div_err_q, div_err_d;
  logic              load_ok_s;
  logic              clear_s;
  logic              term_s;
  logic              adv_s;

  assign load_ok_s = div_load && (div_int >= DIV_W'(baud_pkg::MIN_DIV));
  assign clear_s   = load_ok_s || restart;
  // A terminal coincident with a clear produces no tick and no phase step.
  assign adv_s     = term_s && !clear_s;

  baud_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .clear_i   (clear_s),
    .int_i     (int_q),
    .frac_i    (frac_q),
    .term_o    (term_s),
    .tick_os_o (tick_os)
  );

  // Divisor shadow, phase counter and strobe next-state.
  always_comb begin
    int_d       = int_q;
    frac_d      = frac_q;
    ph_d        = ph_q;
    tick_baud_d = 1'b0;
    tick_mid_d  = 1'b0;
    div_err_d   = div_load && !load_ok_s;
    if (load_ok_s) begin
      int_d  = div_int;
      frac_d = div_frac;
    end else begin
      int_d  = int_q;
      frac_d = frac_q;
    end
    if (clear_s) begin
      ph_d = {PH_W{1'b0}};
    end else if (adv_s) begin
      ph_d        = ph_q + {{(PH_W-1){1'b0}}, 1'b1};
      tick_baud_d = (ph_q == PH_W'(OVS - 1));
      tick_mid_d  = (ph_q == PH_W'(OVS / 2 - 1));
    end else begin
      ph_d = ph_q;
    end
  end

  // Registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_q       <= DIV_W'(DEF_INT);
      frac_q      <= FRAC_W'(DEF_FRAC);
      ph_q        <= {PH_W{1'b0}};
      tick_baud_q <= 1'b0;
      tick_mid_q  <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      int_q       <= int_d;
      frac_q      <= frac_d;
      ph_q        <= ph_d;
      tick_baud_q <= tick_baud_d;
      tick_mid_q  <= tick_mid_d;
      div_err_q   <= div_err_d;
    end
  end

  assign tick_baud = tick_baud_q;
  assign tick_mid  = tick_mid_q;
  assign div_err   = div_err_q;

endmodule

// File: tb/tb_baud_gen_prog.sv
// Directed bench for baud_gen_prog: cadence, loads, restart, enable gating.
module tb_baud_gen_prog;

  logic        clk;
  logic        rst;
  logic        en;
  logic        div_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        restart;
  logic        tick_os;
  logic        tick_baud;
  logic        tick_mid;
  logic        div_err;

  int cyc;
  int total;
  int bad;

  baud_gen_prog dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_load  (div_load),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .restart   (restart),
    .tick_os   (tick_os),
    .tick_baud (tick_baud),
    .tick_mid  (tick_mid),
    .div_err   (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the index of the preceding rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total = total + 1;
    if (got != exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sel: 0 tick_os, 1 tick_mid, 2 tick_baud. Returns -1 when the budget expires.
  task automatic wait_sig(input int sel, input int budget, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0:       s = tick_os;
        1:       s = tick_mid;
        default: s = tick_baud;
      endcase
      if (s === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  int r, t, prev, b1, bb, ev, tt, p, quiet;
  int exp_gap[4];

  initial begin
    cyc = 0; total = 0; bad = 0;
    rst = 1'b1; en = 1'b1; div_load = 1'b0; div_int = 16'd0;
    div_frac = 4'd0; restart = 1'b0;
    exp_gap[0] = 54; exp_gap[1] = 54; exp_gap[2] = 54; exp_gap[3] = 55;

    repeat (3) @(negedge clk);
    chk("rst_tick_os", int'(tick_os), 0);
    chk("rst_tick_baud", int'(tick_baud), 0);
    chk("rst_tick_mid", int'(tick_mid), 0);
    chk("rst_div_err", int'(div_err), 0);
    rst = 1'b0;
    r = cyc;

    // Default cadence 54.25: intervals 54,54,54,55 repeating
    wait_sig(0, 200, t);
    chk("first_os", t - r, 54);
    prev = t;
    for (int k = 0; k < 4; k++) begin
      wait_sig(0, 200, t);
      chk("os_gap", t - prev, exp_gap[k]);
      prev = t;
    end
    wait_sig(1, 1000, t);
    chk("first_mid", t - r, 433);
    wait_sig(2, 1000, b1);
    chk("first_baud", b1 - r, 867);
    chk("baud_with_os", int'(tick_os), 1);
    bb = b1;
    for (int k = 0; k < 4; k++) wait_sig(2, 1000, bb);
    chk("four_bauds", bb - b1, 3472);

    // Rejected load: error pulse, cadence untouched
    repeat (100) @(negedge clk);
    div_int = 16'd1; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    chk("err_pulse", int'(div_err), 1);
    @(negedge clk);
    chk("err_single", int'(div_err), 0);
    wait_sig(2, 1000, t);
    chk("reject_no_phase", t - bb, 868);
    bb = t;

    // Restart mid-interval
    repeat (20) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    ev = cyc;
    chk("restart_quiet", int'(tick_os), 0);
    wait_sig(0, 200, t);
    chk("restart_os", t - ev, 54);
    wait_sig(1, 1000, tt);
    chk("restart_mid", tt - ev, 433);

    // Enable low for 37 clocks inside a 55-clock interval
    repeat (10) @(negedge clk);
    en = 1'b0;
    quiet = 0;
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      if (tick_os === 1'b1 || tick_mid === 1'b1 || tick_baud === 1'b1) quiet = quiet + 1;
    end
    en = 1'b1;
    chk("en_low_quiet", quiet, 0);
    wait_sig(0, 200, t);
    chk("en_late", t - tt, 55 + 37);

    // Load int=10 frac=0
    @(negedge clk);
    div_int = 16'd10; div_frac = 4'd0; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    ev = cyc;
    chk("load_no_err", int'(div_err), 0);
    wait_sig(0, 200, t);
    chk("load_os", t - ev, 10);
    wait_sig(1, 200, t);
    chk("load_mid", t - ev, 80);
    wait_sig(2, 400, t);
    chk("load_baud", t - ev, 160);
    wait_sig(2, 400, p);
    chk("load_baud_gap", p - t, 160);

    // Load and restart exactly on the terminal edge
    repeat (9) @(negedge clk);
    div_int = 16'd20; div_frac = 4'd0; div_load = 1'b1; restart = 1'b1;
    @(negedge clk);
    div_load = 1'b0; restart = 1'b0;
    chk("term_clear_os", int'(tick_os), 0);
    chk("term_clear_mid", int'(tick_mid), 0);
    wait_sig(0, 200, t);
    chk("new_os", t - p, 30);
    wait_sig(1, 400, t);
    chk("new_mid", t - p, 170);

    // Reset wins over a coincident load and restart
    @(negedge clk);
    rst = 1'b1; div_int = 16'd10; div_load = 1'b1; restart = 1'b1;
    @(negedge clk);
    chk("rst_prio_os", int'(tick_os), 0);
    chk("rst_prio_err", int'(div_err), 0);
    rst = 1'b0; div_load = 1'b0; restart = 1'b0;
    r = cyc;
    wait_sig(0, 200, t);
    chk("rst_prio_div", t - r, 54);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
